// File: rtl/scsi_xfer_pkg.sv
// Shared types and constants for the SCSI-side byte transfer sequencer.
package scsi_xfer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE,
        ST_HOLD,
        ST_ADV,
        ST_FLUSHW
    } xfer_state_t;

    localparam logic DIR_S2F = 1'b0;
    localparam logic DIR_F2S = 1'b1;

    localparam logic [1:0] LANE_MSB = 2'd0;
    localparam logic [1:0] LANE_LSB = 2'd3;

    localparam int TMR_W = 8;

    // Byte lane pointer advances modulo 4, MSB lane first.
    function automatic logic [1:0] lane_next(input logic [1:0] bo);
        return bo + 2'd1;
    endfunction

endpackage

// File: rtl/scsi_xfer_ctrl_xfer_timer.sv
// Loadable down counter timing the strobe and hold phases of each byte.
module xfer_timer
    import scsi_xfer_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - W'(1);
        end
    end

    assign done = (cnt_reg == '0);

endmodule

// File: rtl/scsi_xfer_ctrl.sv
// SCSI byte handshake sequencer: SDREQ/SDACK, SIOR/SIOW strobes, lane steering
// and longword packing/unpacking towards the FIFO.
module scsi_xfer_ctrl
    import scsi_xfer_pkg::*;
#(
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1,
    parameter int BCNT_W     = 24
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              DMAENA,
    input  logic              DMADIR,
    input  logic              SDREQ,
    input  logic              FIFOFULL,
    input  logic              FIFOEMPTY,
    input  logic              FLUSH,
    input  logic              CLRCNT,
    output logic              SDACK,
    output logic              SIOR,
    output logic              SIOW,
    output logic              S2F,
    output logic              F2S,
    output logic              BO0,
    output logic              BO1,
    output logic              INCFIFO,
    output logic              DECFIFO,
    output logic              FLUSH_DONE,
    output logic              BUSY,
    output logic [BCNT_W-1:0] BCNT
);

    localparam logic [TMR_W-1:0] STROBE_LD = TMR_W'(STROBE_CYC - 1);
    localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(HOLD_CYC - 1);

    xfer_state_t       state_reg;
    logic [1:0]        bo_reg;
    logic              dir_reg;
    logic [BCNT_W-1:0] bcnt_reg;

    logic              fifo_ok;
    logic              dir_mismatch;
    logic              start_byte;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_done;

    // A pending partial word belongs to the direction latched at its last byte.
    assign fifo_ok      = (DMADIR == DIR_S2F) ? ((bo_reg != LANE_LSB) || !FIFOFULL) : !FIFOEMPTY;
    assign dir_mismatch = (bo_reg != LANE_MSB) && (DMADIR != dir_reg);
    assign start_byte   = (state_reg == ST_IDLE) && !FLUSH && DMAENA && SDREQ
                          && fifo_ok && !dir_mismatch;
    assign tmr_load     = start_byte || ((state_reg == ST_STROBE) && tmr_done);
    assign tmr_val      = start_byte ? STROBE_LD : HOLD_LD;

    xfer_timer #(.W(TMR_W)) u_timer (
        .clk      (CLK),
        .srst     (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= ST_IDLE;
            bo_reg     <= LANE_MSB;
            dir_reg    <= DIR_S2F;
            bcnt_reg   <= '0;
            SDACK      <= 1'b0;
            SIOR       <= 1'b0;
            SIOW       <= 1'b0;
            S2F        <= 1'b0;
            F2S        <= 1'b0;
            INCFIFO    <= 1'b0;
            DECFIFO    <= 1'b0;
            FLUSH_DONE <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            INCFIFO    <= 1'b0;
            DECFIFO    <= 1'b0;
            FLUSH_DONE <= 1'b0;

            if (CLRCNT) begin
                bcnt_reg <= '0;
            end else if ((state_reg == ST_HOLD) && tmr_done) begin
                bcnt_reg <= bcnt_reg + BCNT_W'(1);
            end

            case (state_reg)
                ST_IDLE: begin
                    if (FLUSH) begin
                        if (bo_reg == LANE_MSB) begin
                            FLUSH_DONE <= 1'b1;
                        end else if (DMADIR == DIR_S2F) begin
                            state_reg <= ST_FLUSHW;
                            BUSY      <= 1'b1;
                        end else begin
                            DECFIFO    <= 1'b1;
                            bo_reg     <= LANE_MSB;
                            FLUSH_DONE <= 1'b1;
                        end
                    end else if (start_byte) begin
                        state_reg <= ST_STROBE;
                        BUSY      <= 1'b1;
                        SDACK     <= 1'b1;
                        dir_reg   <= DMADIR;
                        SIOR      <= (DMADIR == DIR_S2F);
                        SIOW      <= (DMADIR == DIR_F2S);
                        S2F       <= (DMADIR == DIR_S2F);
                        F2S       <= (DMADIR == DIR_F2S);
                    end else if (dir_mismatch) begin
                        bo_reg <= LANE_MSB;
                    end
                end
                ST_STROBE: begin
                    if (tmr_done) begin
                        state_reg <= ST_HOLD;
                        SIOR      <= 1'b0;
                        SIOW      <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (tmr_done) begin
                        state_reg <= ST_ADV;
                        SDACK     <= 1'b0;
                        bo_reg    <= lane_next(bo_reg);
                        if (bo_reg == LANE_LSB) begin
                            INCFIFO <= (dir_reg == DIR_S2F);
                            DECFIFO <= (dir_reg == DIR_F2S);
                        end
                    end
                end
                ST_ADV: begin
                    state_reg <= ST_IDLE;
                    BUSY      <= 1'b0;
                    S2F       <= 1'b0;
                    F2S       <= 1'b0;
                end
                ST_FLUSHW: begin
                    if (!FIFOFULL) begin
                        state_reg  <= ST_IDLE;
                        BUSY       <= 1'b0;
                        INCFIFO    <= 1'b1;
                        bo_reg     <= LANE_MSB;
                        FLUSH_DONE <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    BUSY      <= 1'b0;
                    SDACK     <= 1'b0;
                    SIOR      <= 1'b0;
                    SIOW      <= 1'b0;
                    S2F       <= 1'b0;
                    F2S       <= 1'b0;
                end
            endcase
        end
    end

    assign {BO1, BO0} = bo_reg;
    assign BCNT       = bcnt_reg;

endmodule
